// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product accumulator: state encoding,
// drain length and a constant-evaluable log2 used for adder-tree depth.
package dot_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_RUN   = 2'd1;
    localparam logic [1:0] STATE_DRAIN = 2'd2;
    localparam logic [1:0] STATE_DONE  = 2'd3;

    localparam int DRAIN_CYCLES = 32'd2;

    typedef enum logic [1:0] {
        S_IDLE  = STATE_IDLE,
        S_RUN   = STATE_RUN,
        S_DRAIN = STATE_DRAIN,
        S_DONE  = STATE_DONE
    } dot_state_t;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 32'd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational pairwise reduction of LANES values of ACC_W bits, modulo
// 2^ACC_W. The parent registers the sum as pipeline stage 2.
module lane_adder_tree
    import dot_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACC_W = 32
) (
    input  logic [LANES*ACC_W-1:0] values,
    output logic [ACC_W-1:0]       sum
);

    localparam int DEPTH = clog2(LANES);

    // Level l holds LANES>>l partial sums; level DEPTH is the single root.
    for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
        localparam int N = LANES >> l;
        logic [ACC_W-1:0] vals_s [N];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_in
                assign vals_s[i] = values[i*ACC_W +: ACC_W];
            end
        end else begin : g_node
            for (genvar i = 0; i < N; i++) begin : g_add
                assign vals_s[i] = g_lvl[l-1].vals_s[2*i] + g_lvl[l-1].vals_s[2*i+1];
            end
        end
    end

    assign sum = g_lvl[DEPTH].vals_s[0];

endmodule

// File: rtl/dot_product_acc.sv
// Pipelined LANES-wide dot-product engine: multiply stage, adder-tree stage and
// accumulator, sequenced by an IDLE/RUN/DRAIN/DONE controller.
module dot_product_acc
    import dot_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    accumulate,
    input  logic [LANES*DATA_W-1:0] in_set_one,
    input  logic [LANES*DATA_W-1:0] in_set_two,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [ACC_W-1:0]        result,
    output logic [CNT_W-1:0]        beat_count,
    output logic                    done,
    input  logic                    ack
);

    localparam bit LANES_OK = (LANES >= 1) && (LANES <= 16) &&
                              ((32'sd1 <<< clog2(LANES)) == LANES);
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    if (!LANES_OK) begin : g_bad_lanes
        $fatal(1, "dot_product_acc: LANES must be a power of two in 1..16");
    end

    dot_state_t             state_r;
    logic                   in_ready_r;
    logic                   done_r;
    logic [CNT_W-1:0]       beat_cnt_r;
    logic [1:0]             drain_cnt_r;
    logic [LANES*ACC_W-1:0] prod_s;
    logic [LANES*ACC_W-1:0] prod_r;
    logic                   s1_valid_r;
    logic [ACC_W-1:0]       sum_s;
    logic [ACC_W-1:0]       sum_r;
    logic                   s2_valid_r;
    logic [ACC_W-1:0]       acc_r;
    logic                   accept_s;
    logic                   clear_acc_s;

    assign accept_s    = in_valid && in_ready_r;
    assign clear_acc_s = (state_r == S_IDLE) && start && !accumulate;

    // Operands are narrowed to ACC_W first: the low ACC_W product bits only
    // depend on the low ACC_W operand bits, so the modulo result is unchanged.
    for (genvar i = 0; i < LANES; i++) begin : g_mul
        assign prod_s[i*ACC_W +: ACC_W] =
            ACC_W'(in_set_one[i*DATA_W +: DATA_W]) * ACC_W'(in_set_two[i*DATA_W +: DATA_W]);
    end

    lane_adder_tree #(
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) u_tree (
        .values (prod_r),
        .sum    (sum_s)
    );

    // Stage 1 products and stage 2 tree sum, each with its valid bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_r     <= '0;
            s1_valid_r <= 1'b0;
            sum_r      <= '0;
            s2_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                prod_r <= prod_s;
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                sum_r <= sum_s;
            end
        end
    end

    // Stage 3 accumulator; clearing only happens in IDLE when the pipe is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= '0;
        end else if (clear_acc_s) begin
            acc_r <= '0;
        end else if (s2_valid_r) begin
            acc_r <= acc_r + sum_r;
        end
    end

    // Run controller with registered in_ready, done and beat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b0;
            done_r      <= 1'b0;
            beat_cnt_r  <= '0;
            drain_cnt_r <= 2'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r    <= S_RUN;
                        in_ready_r <= 1'b1;
                        beat_cnt_r <= '0;
                    end
                end
                S_RUN: begin
                    if (accept_s) begin
                        if (beat_cnt_r != {CNT_W{1'b1}}) begin
                            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        end
                        if (in_last) begin
                            state_r     <= S_DRAIN;
                            in_ready_r  <= 1'b0;
                            drain_cnt_r <= 2'd0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state_r <= S_IDLE;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    in_ready_r <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign done       = done_r;
    assign beat_count = beat_cnt_r;
    assign result     = acc_r;

endmodule

// File: tb/tb_dot_product_acc.sv
// Directed self-checking bench for dot_product_acc at default parameters.
module tb_dot_product_acc;

    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 16;
    localparam int VW     = LANES * DATA_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             accumulate;
    logic [VW-1:0]    in_set_one;
    logic [VW-1:0]    in_set_two;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] result;
    logic [CNT_W-1:0] beat_count;
    logic             done;
    logic             ack;

    int checks   = 0;
    int failures = 0;

    logic [VW-1:0] va = {32'd4, 32'd3, 32'd2, 32'd1};
    logic [VW-1:0] vb = {32'd8, 32'd7, 32'd6, 32'd5};

    dot_product_acc #(
        .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .accumulate (accumulate),
        .in_set_one (in_set_one),
        .in_set_two (in_set_two),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .result     (result),
        .beat_count (beat_count),
        .done       (done),
        .ack        (ack)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] rep(input logic [DATA_W-1:0] v);
        return {LANES{v}};
    endfunction

    // Stimulus helpers: each starts and ends just after a falling edge.
    task automatic start_run(input logic accum);
        start = 1'b1;
        accumulate = accum;
        @(negedge clk);
        start = 1'b0;
        accumulate = 1'b0;
    endtask

    task automatic send_beat(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic last);
        in_set_one = a;
        in_set_two = b;
        in_valid = 1'b1;
        in_last = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 10 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: done=%b required 1", done);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; accumulate = 1'b0; ack = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_set_one = '0; in_set_two = '0;
        repeat (2) @(negedge clk);
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result: got %0d want 0", result); end
        checks++; if (beat_count !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", beat_count); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        in_set_one = va; in_set_two = vb; in_valid = 1'b1; in_last = 1'b1;
        start = 1'b1; accumulate = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_e1: got %b want 0", done); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL single_ready_fall: got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_e2: got %b want 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done_e3: got %b want 1", done); end
        checks++; if (result !== 32'd70) begin failures++; $display("FAIL single_result: got %0d want 70", result); end
        checks++; if (beat_count !== 16'd1) begin failures++; $display("FAIL single_count: got %0d want 1", beat_count); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done_held: got %b want 1", done); end
        do_ack();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_ack: got %b want 0", done); end
        checks++; if (result !== 32'd70) begin failures++; $display("FAIL single_result_kept: got %0d want 70", result); end
    endtask

    task automatic test_accumulate();
        start_run(1'b1);
        send_beat(va, vb, 1'b1);
        wait_done();
        checks++; if (result !== 32'd140) begin failures++; $display("FAIL accum_result: got %0d want 140", result); end
        do_ack();
        start_run(1'b0);
        send_beat(va, vb, 1'b1);
        wait_done();
        checks++; if (result !== 32'd70) begin failures++; $display("FAIL clear_result: got %0d want 70", result); end
        checks++; if (beat_count !== 16'd1) begin failures++; $display("FAIL clear_count: got %0d want 1", beat_count); end
        do_ack();
    endtask

    task automatic test_back_to_back();
        start_run(1'b0);
        send_beat(rep(32'd1), rep(32'd1), 1'b0);
        send_beat(rep(32'd2), rep(32'd3), 1'b0);
        send_beat(rep(32'd10), rep(32'd10), 1'b1);
        wait_done();
        checks++; if (result !== 32'd428) begin failures++; $display("FAIL b2b_result: got %0d want 428", result); end
        checks++; if (beat_count !== 16'd3) begin failures++; $display("FAIL b2b_count: got %0d want 3", beat_count); end
        do_ack();
    endtask

    task automatic test_wrap();
        start_run(1'b0);
        send_beat(rep(32'hFFFF_FFFF), rep(32'hFFFF_FFFF), 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (result !== 32'd4) begin failures++; $display("FAIL wrap_first: got %0d want 4", result); end
        send_beat(rep(32'h8000_0000), rep(32'd2), 1'b1);
        wait_done();
        checks++; if (result !== 32'd4) begin failures++; $display("FAIL wrap_second: got %0d want 4", result); end
        checks++; if (beat_count !== 16'd2) begin failures++; $display("FAIL wrap_count: got %0d want 2", beat_count); end
        do_ack();
    endtask

    task automatic test_handshake();
        start_run(1'b0);
        start = 1'b1; ack = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0; ack = 1'b0;
        checks++; if (beat_count !== 16'd0) begin failures++; $display("FAIL gap_count0: got %0d want 0", beat_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL gap_ready: got %b want 1", in_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL early_ack_done: got %b want 0", done); end
        send_beat(rep(32'd1), rep(32'd2), 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (beat_count !== 16'd1) begin failures++; $display("FAIL run_start_count: got %0d want 1", beat_count); end
        in_set_one = rep(32'd1); in_set_two = rep(32'd1); in_valid = 1'b1; in_last = 1'b1;
        @(negedge clk);
        in_set_one = rep(32'd10); in_set_two = rep(32'd10); in_last = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL held_valid_ready: got %b want 0", in_ready); end
        @(negedge clk);
        in_last = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL held_done: got %b want 1", done); end
        checks++; if (result !== 32'd12) begin failures++; $display("FAIL held_result: got %0d want 12", result); end
        repeat (2) @(negedge clk);
        checks++; if (result !== 32'd12) begin failures++; $display("FAIL held_result_late: got %0d want 12", result); end
        checks++; if (beat_count !== 16'd2) begin failures++; $display("FAIL held_count: got %0d want 2", beat_count); end
        in_valid = 1'b0; in_last = 1'b0;
        ack = 1'b1; start = 1'b1;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ack_start_done: got %b want 0", done); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ack_start_ready: got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ack_start_idle: got %b want 0", in_ready); end
    endtask

    task automatic test_reset_mid();
        start_run(1'b1);
        send_beat(va, vb, 1'b1);
        checks++; if (beat_count !== 16'd1) begin failures++; $display("FAIL mid_pre_count: got %0d want 1", beat_count); end
        reset = 1'b0;
        #1;
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL mid_result: got %0d want 0", result); end
        checks++; if (beat_count !== 16'd0) begin failures++; $display("FAIL mid_count: got %0d want 0", beat_count); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done: got %b want 0", done); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_ready: got %b want 0", in_ready); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_after_done: got %b want 0", done); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL mid_after_result: got %0d want 0", result); end
        start_run(1'b0);
        send_beat(va, vb, 1'b1);
        wait_done();
        checks++; if (result !== 32'd70) begin failures++; $display("FAIL mid_rerun_result: got %0d want 70", result); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_single();
        test_accumulate();
        test_back_to_back();
        test_wrap();
        test_handshake();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
